// File: rtl/spi_slave.sv
// SPI target, CPOL=0 / CPHA=0, active-low chip enable.
// Serial inputs are synchronized and edge-detected in the i_clk domain.
module spi_slave #(
  parameter int WORD_SIZE   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sck,
  input  logic                 i_sce,
  input  logic                 i_sin,
  output logic                 o_sout,
  output logic                 o_soe,
  input  logic [WORD_SIZE-1:0] i_win,
  output logic [WORD_SIZE-1:0] o_wout,
  output logic                 o_wstb,
  output logic                 o_err,
  output logic                 o_busy
);

  localparam int CW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_sce_sync;
  logic [SYNC_STAGES-1:0] r_sin_sync;
  logic                   r_sck_d;
  logic                   r_sce_d;

  logic [WORD_SIZE-1:0] r_tx;
  logic [WORD_SIZE-1:0] r_rx;
  logic [WORD_SIZE-1:0] r_wout;
  logic [CW-1:0]        r_cnt;
  logic                 r_reload;
  logic                 r_wstb;
  logic                 r_err;

  logic w_sck_s;
  logic w_sce_s;
  logic w_sin_s;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_ce_fall;
  logic w_ce_rise;
  logic w_load;
  logic w_shin;
  logic w_shout;
  logic w_err;
  logic [WORD_SIZE-1:0] w_rx_nxt;

  // Synchronizers reset to the idle bus: SCK low, CE deasserted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sck_sync <= '0;
      r_sce_sync <= '1;
      r_sin_sync <= '0;
      r_sck_d    <= 1'b0;
      r_sce_d    <= 1'b1;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_sce_sync <= {r_sce_sync[SYNC_STAGES-2:0], i_sce};
      r_sin_sync <= {r_sin_sync[SYNC_STAGES-2:0], i_sin};
      r_sck_d    <= w_sck_s;
      r_sce_d    <= w_sce_s;
    end
  end

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_sce_s    = r_sce_sync[SYNC_STAGES-1];
  assign w_sin_s    = r_sin_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_d & ~w_sce_s;
  assign w_sck_fall = ~w_sck_s & r_sck_d & ~w_sce_s;
  assign w_ce_fall  = ~w_sce_s & r_sce_d;
  assign w_ce_rise  = w_sce_s & ~r_sce_d;
  assign w_rx_nxt   = {r_rx[WORD_SIZE-2:0], w_sin_s};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shin      = 1'b0;
    w_shout     = 1'b0;
    w_err       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ce_fall) begin
          if (!w_sck_s) begin
            w_load      = 1'b1;
            w_state_nxt = ACTIVE;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = DROP;
          end
        end
      end
      ACTIVE: begin
        // CE rise beats a coincident SCK edge
        if (w_ce_rise) begin
          w_err       = (r_cnt != LAST);
          w_state_nxt = IDLE;
        end else if (w_sck_rise) begin
          w_shin = 1'b1;
        end else if (w_sck_fall) begin
          w_shout = 1'b1;
        end
      end
      DROP: begin
        if (w_ce_rise) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx     <= '0;
      r_rx     <= '0;
      r_wout   <= '0;
      r_cnt    <= '0;
      r_reload <= 1'b0;
      r_wstb   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_wstb <= 1'b0;
      r_err  <= w_err;
      if (w_load) begin
        r_tx     <= i_win;
        r_rx     <= '0;
        r_cnt    <= LAST;
        r_reload <= 1'b0;
      end
      if (w_shin) begin
        r_rx <= w_rx_nxt;
        if (r_cnt == '0) begin
          r_wout   <= w_rx_nxt;
          r_wstb   <= 1'b1;
          r_cnt    <= LAST;
          r_reload <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
      if (w_shout) begin
        if (r_reload) begin
          r_tx     <= i_win;
          r_reload <= 1'b0;
        end else begin
          r_tx <= r_tx << 1;
        end
      end
    end
  end

  assign o_soe  = (r_state == ACTIVE);
  assign o_sout = (r_state == ACTIVE) & r_tx[WORD_SIZE-1];
  assign o_busy = (r_state != IDLE);
  assign o_wout = r_wout;
  assign o_wstb = r_wstb;
  assign o_err  = r_err;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed plan cases plus random frames
// checked against a word-level model of the SPI exchange.
module tb_spi_slave;

  localparam int WS = 16;
  localparam int SS = 2;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_sck = 1'b0;
  logic          i_sce = 1'b1;
  logic          i_sin = 1'b0;
  logic          o_sout;
  logic          o_soe;
  logic [WS-1:0] i_win = '0;
  logic [WS-1:0] o_wout;
  logic          o_wstb;
  logic          o_err;
  logic          o_busy;

  spi_slave #(.WORD_SIZE(WS), .SYNC_STAGES(SS)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_sck (i_sck),
    .i_sce (i_sce),
    .i_sin (i_sin),
    .o_sout(o_sout),
    .o_soe (o_soe),
    .i_win (i_win),
    .o_wout(o_wout),
    .o_wstb(o_wstb),
    .o_err (o_err),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_wstb = 0;
  int n_err = 0;
  int wstb_cyc = 0;
  int rise_cyc = 0;

  logic [WS-1:0] mosi_w [6];
  logic [WS-1:0] miso_w [6];
  logic [WS-1:0] win_next;
  logic [WS-1:0] exp_wout;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_wstb) begin
      n_wstb   = n_wstb + 1;
      wstb_cyc = cyc;
    end
    if (o_err) n_err = n_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  // One SCK period, 4 clk low then 4 clk high, MISO sampled before the rise.
  task automatic sck_bit(input logic din, output logic dout);
    i_sin = din;
    repeat (2) tick();
    dout  = o_sout;
    i_sck = 1'b1;
    rise_cyc = cyc;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (o_wstb) i_win = win_next;
    end
    i_sck = 1'b0;
    repeat (2) tick();
  endtask

  task automatic send_frame(input int n, input int extra);
    int e0, s0;
    logic [WS-1:0] got;
    logic b;
    e0 = n_err;
    s0 = n_wstb;
    i_win = miso_w[0];
    tick();
    i_sce = 1'b0;
    repeat (6) tick();
    for (int w = 0; w < n; w++) begin
      win_next = miso_w[w+1];
      for (int k = WS - 1; k >= 0; k--) begin
        sck_bit(mosi_w[w][k], b);
        got[k] = b;
      end
      exp_wout = mosi_w[w];
      chk("miso", got, miso_w[w]);
      chk("wstb_lat", wstb_cyc - rise_cyc, SS + 1);
    end
    for (int k = 0; k < extra; k++) sck_bit(mosi_w[n][WS-1-k], b);
    i_sce = 1'b1;
    repeat (6) tick();
    chk("wstb_cnt", n_wstb - s0, n);
    chk("err_cnt", n_err - e0, (extra > 0) ? 1 : 0);
    chk("wout", o_wout, exp_wout);
    chk("idle", {o_busy, o_soe}, 2'b00);
  endtask

  initial begin
    int e0, s0, n, extra;
    logic [WS-1:0] w0;
    logic b;
    exp_wout = '0;
    win_next = '0;
    for (int i = 0; i < 6; i++) begin
      mosi_w[i] = '0;
      miso_w[i] = '0;
    end
    repeat (3) tick();
    chk("rst_out", {o_sout, o_soe, o_wout, o_wstb, o_err, o_busy}, '0);
    i_rst = 1'b0;
    repeat (3) tick();

    mosi_w[0] = 16'h1234; miso_w[0] = 16'hA5C3;
    send_frame(1, 0);

    mosi_w[0] = 16'hBEEF; miso_w[0] = 16'hA5C3;
    mosi_w[1] = 16'h0F0F; miso_w[1] = 16'h5555;
    send_frame(2, 0);

    mosi_w[0] = 16'hC3C3;
    send_frame(0, 5);

    e0 = n_err; s0 = n_wstb;
    for (int i = 0; i < 20; i++) begin
      i_sck = ~i_sck;
      repeat (4) tick();
    end
    chk("ceh_wstb", n_wstb - s0, 0);
    chk("ceh_err", n_err - e0, 0);
    chk("ceh_soe", o_soe, 1'b0);
    chk("ceh_wout", o_wout, exp_wout);

    e0 = n_err; s0 = n_wstb;
    i_sck = 1'b1;
    repeat (4) tick();
    i_sce = 1'b0;
    repeat (4) tick();
    chk("drop_busy", {o_busy, o_soe}, 2'b10);
    chk("drop_err", n_err - e0, 1);
    for (int i = 0; i < 16; i++) begin
      i_sck = 1'b0; repeat (4) tick();
      i_sck = 1'b1; repeat (4) tick();
    end
    i_sck = 1'b0;
    repeat (4) tick();
    i_sce = 1'b1;
    repeat (6) tick();
    chk("drop_exit", o_busy, 1'b0);
    chk("drop_wstb", n_wstb - s0, 0);
    chk("drop_err2", n_err - e0, 1);
    mosi_w[0] = 16'h00FF; miso_w[0] = 16'h3C5A;
    send_frame(1, 0);

    e0 = n_err; s0 = n_wstb;
    i_win = 16'hFFFF;
    i_sce = 1'b0;
    repeat (6) tick();
    for (int k = 0; k < 7; k++) sck_bit(1'b1, b);
    i_sck = 1'b1;
    #3 i_rst = 1'b1;
    #1 chk("arst_out", {o_sout, o_soe, o_wout, o_wstb, o_err, o_busy}, '0);
    i_sck = 1'b0;
    i_sce = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    exp_wout = '0;
    repeat (3) tick();
    chk("arst_wstb", n_wstb - s0, 0);
    chk("arst_err", n_err - e0, 0);
    mosi_w[0] = 16'h8001; miso_w[0] = 16'h7E81;
    send_frame(1, 0);

    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(1, 3);
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
      for (int i = 0; i < 6; i++) begin
        w0 = WS'($urandom);
        mosi_w[i] = w0;
        miso_w[i] = WS'($urandom);
      end
      send_frame(n, extra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
